// File: rtl/divider_16bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock via a
// 17-bit trial subtraction, with a start/busy/done handshake.
module divider_16bit_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_sh, r_reg, d_reg;
  logic [CNT_W-1:0] cnt;
  logic             accept, last_iter, no_borrow;
  logic [WIDTH:0]   trial, diff;
  logic [WIDTH-1:0] r_nxt, q_nxt;

  // Partial remainder plus inverted divisor with carry-in: T - D, bit WIDTH is the borrow.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] t,
                                               input logic [WIDTH-1:0] d);
    return t + {1'b1, ~d} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  assign accept    = start && (state != RUN);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign trial     = {r_reg, q_sh[WIDTH-1]};
  assign diff      = trial_sub(trial, d_reg);
  assign no_borrow = ~diff[WIDTH];
  assign r_nxt     = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt     = {q_sh[WIDTH-2:0], no_borrow};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = (divisor != '0) ? RUN : DONE;
        else        state_nxt = IDLE;
      end
      RUN:     if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Results are written on the edge that enters DONE, so they are valid with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_sh        <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        q_sh  <= dividend;
        d_reg <= divisor;
        r_reg <= '0;
        cnt   <= '0;
      end else begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == RUN) begin
      q_sh  <= q_nxt;
      r_reg <= r_nxt;
      cnt   <= cnt + CNT_W'(1);
      if (last_iter) begin
        quotient    <= q_nxt;
        remainder   <= r_nxt;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_16bit_seq.sv
// Self-checking bench for divider_16bit_seq: cycle-level behavioural model
// using plain / and %, directed literal cases, and randomized operands.
module tb_divider_16bit_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, div_by_zero;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model state: cycles of iteration left, pending result, visible outputs.
  int          m_remain = 0;
  logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        m_done = 1'b0, m_dbz = 1'b0;
  logic        exp_busy;

  divider_16bit_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      m_remain = 0; m_q = '0; m_r = '0; m_dbz = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_q = p_q; m_r = p_r; m_dbz = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        if (divisor == 16'd0) begin
          m_q = 16'hFFFF; m_r = dividend; m_dbz = 1'b1; m_done = 1'b1;
        end else begin
          p_q = dividend / divisor; p_r = dividend % divisor; m_remain = 16;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      exp_busy = (m_remain != 0);
      total++;
      if ({busy, done, div_by_zero, quotient, remainder} !== {exp_busy, m_done, m_dbz, m_q, m_r}) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dbz=%b q=%0d r=%0d required busy=%b done=%b dbz=%b q=%0d r=%0d",
                 $time, busy, done, div_by_zero, quotient, remainder, exp_busy, m_done, m_dbz, m_q, m_r);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Issue one divide at the current negedge and wait (bounded) for done.
  // inj_at > 0 re-asserts start with other operands that many cycles later.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                         input int elat, input string name,
                         input int inj_at, input logic [15:0] inj_a, input logic [15:0] inj_b);
    int n;
    dividend = a; divisor = b; start = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == inj_at) begin
        start = 1'b1; dividend = inj_a; divisor = inj_b;
      end else begin
        start = 1'b0;
      end
    end while (!done && n < 40);
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done after %0d cycles, required done", name, n);
    end else begin
      check({name, "_lat"}, n, elat);
      check({name, "_q"}, quotient, eq);
      check({name, "_r"}, remainder, er);
      check({name, "_dbz"}, div_by_zero, edbz);
    end
  endtask

  initial begin
    int dones;
    logic [15:0] a, b;
    repeat (2) @(negedge clk);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_flags", {busy, done, div_by_zero}, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, "d100_7", -1, 0, 0);
    run_div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17, "dffff_1", -1, 0, 0);
    run_div(16'hFFFF, 16'h8001, 16'd1, 16'h7FFE, 1'b0, 17, "dffff_8001", -1, 0, 0);
    run_div(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17, "d3_10", -1, 0, 0);
    run_div(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 17, "d0_5", -1, 0, 0);
    @(negedge clk);
    run_div(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1, "d5_0", -1, 0, 0);
    run_div(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, "d9_3", -1, 0, 0);
    @(negedge clk);
    run_div(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 17, "start_in_run", 5, 16'd50, 16'd5);
    run_div(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17, "back_to_back", -1, 0, 0);

    // Reset in the middle of an iteration.
    dividend = 16'd1234; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_flags", {busy, done, div_by_zero}, 0);
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_div(16'd1234, 16'd5, 16'd246, 16'd4, 1'b0, 17, "d1234_5", -1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'h8000 | 16'($urandom);
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      if (b == 16'd0) run_div(a, b, 16'hFFFF, a, 1'b1, 1, "rnd", -1, 0, 0);
      else            run_div(a, b, a / b, a % b, 1'b0, 17, "rnd", -1, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
